// File: rtl/crop_decimator.sv
// Window crop with integer nearest-neighbour decimation (1..4) on a vs/de/RGB888 stream.
// One clock of latency on every output; EN=0 turns the stage into a plain register.
module crop_decimator #(
  parameter logic [11:0] H_MAX = 12'd1280,
  parameter logic [11:0] V_MAX = 12'd720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [11:0] x_start,
  input  logic [11:0] y_start,
  input  logic [11:0] crop_w,
  input  logic [11:0] crop_h,
  input  logic [1:0]  h_dec,
  input  logic [1:0]  v_dec,
  input  logic        pre_vs,
  input  logic        pre_de,
  input  logic [23:0] pre_data,
  output logic        post_vs,
  output logic        post_de,
  output logic [23:0] post_data
);

  logic [11:0] x_cnt, y_cnt;
  logic [1:0]  h_ph, v_ph;
  logic [11:0] sx, sy, sw, sh;
  logic [1:0]  sh_dec, sv_dec;
  logic        frame_ok;
  logic        vs_d, de_d;

  logic        frame_start, line_end;
  logic [12:0] x_end, y_end;
  logic        col_in, row_in, keep;

  // Window ends are 13-bit so sx+sw never wraps back into the line.
  assign x_end       = {1'b0, sx} + {1'b0, sw};
  assign y_end       = {1'b0, sy} + {1'b0, sh};
  assign frame_start = pre_vs && !vs_d;
  assign line_end    = !pre_de && de_d;
  assign col_in      = (x_cnt >= sx) && ({1'b0, x_cnt} < x_end);
  assign row_in      = (y_cnt >= sy) && ({1'b0, y_cnt} < y_end);
  assign keep        = frame_ok && pre_de && col_in && (h_ph == 2'd0)
                       && row_in && (v_ph == 2'd0);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_data <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      h_ph      <= '0;
      v_ph      <= '0;
      sx        <= '0;
      sy        <= '0;
      sw        <= H_MAX;
      sh        <= V_MAX;
      sh_dec    <= '0;
      sv_dec    <= '0;
      frame_ok  <= 1'b0;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
    end else begin
      vs_d    <= pre_vs;
      de_d    <= pre_de;
      post_vs <= pre_vs;

      if (EN) begin
        post_de   <= keep;
        post_data <= keep ? pre_data : 24'd0;
      end else begin
        post_de   <= pre_de;
        post_data <= pre_data;
      end

      // Config is sampled only at frame start so a frame is never torn.
      if (frame_start) begin
        sx       <= x_start;
        sy       <= y_start;
        sw       <= crop_w;
        sh       <= crop_h;
        sh_dec   <= h_dec;
        sv_dec   <= v_dec;
        frame_ok <= 1'b1;
      end

      if (pre_vs) begin
        x_cnt <= '0;
        y_cnt <= '0;
        h_ph  <= '0;
        v_ph  <= '0;
      end else if (line_end) begin
        x_cnt <= '0;
        h_ph  <= '0;
        if (y_cnt != 12'hfff) y_cnt <= y_cnt + 12'd1;
        if (row_in) v_ph <= (v_ph == sv_dec) ? 2'd0 : v_ph + 2'd1;
      end else if (pre_de) begin
        if (x_cnt != 12'hfff) x_cnt <= x_cnt + 12'd1;
        if (col_in) h_ph <= (h_ph == sh_dec) ? 2'd0 : h_ph + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_crop_decimator.sv
// Scoreboard bench for crop_decimator on small 16x8 frames: the driver queues the
// expected pixel and its arrival cycle, and a negedge monitor matches post_de against it.
module tb_crop_decimator;

  localparam int L_PIX   = 16;
  localparam int N_LINES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_pin;
  logic [11:0] x_start, y_start, crop_w, crop_h;
  logic [1:0]  h_dec, v_dec;
  logic        pre_vs, pre_de;
  logic [23:0] pre_data;
  logic        post_vs, post_de;
  logic [23:0] post_data;

  crop_decimator dut (
    .clk(clk), .rst(rst), .EN(en_pin),
    .x_start(x_start), .y_start(y_start), .crop_w(crop_w), .crop_h(crop_h),
    .h_dec(h_dec), .v_dec(v_dec),
    .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  bit   exp_vs[int];
  bit   exp_en[int];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   out_cnt = 0;

  logic en;
  bit   fok, prev_vs;
  int   m_sx, m_sy, m_sw, m_sh, m_hd, m_vd;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit inwin(input int p, input int s, input int w, input int d);
    return (p >= s) && (p < s + w) && (((p - s) % (d + 1)) == 0);
  endfunction

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missing_pixel", post_de, 1'b1);
      void'(sb.pop_front());
    end
    if (exp_vs.exists(cyc)) check("post_vs", post_vs, exp_vs[cyc]);
    if (post_de === 1'b1) begin
      out_cnt++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        check("unexpected_post_de", post_de, 1'b0);
      end else begin
        check("post_data", post_data, sb[0].data);
        void'(sb.pop_front());
      end
    end else if (exp_en.exists(cyc) && exp_en[cyc]) begin
      check("data_zero", post_data, 24'd0);
    end
  end

  task automatic step(input bit r, input bit vs, input bit de, input int c, input int row);
    logic [23:0] d;
    bit          k;
    @(posedge clk);
    #1;
    d        = 24'($urandom);
    rst      = r;
    en_pin   = en;
    pre_vs   = vs;
    pre_de   = de;
    pre_data = d;
    exp_vs[cyc + 1] = r ? 1'b0 : vs;
    exp_en[cyc + 1] = !r && en;
    if (r) begin
      fok     = 1'b0;
      prev_vs = 1'b0;
    end else begin
      k = en ? (fok && de && inwin(c, m_sx, m_sw, m_hd) && inwin(row, m_sy, m_sh, m_vd)) : de;
      if (k) sb.push_back('{cyc + 1, d});
      if (vs && !prev_vs) begin
        fok  = 1'b1;
        m_sx = int'(x_start); m_sy = int'(y_start);
        m_sw = int'(crop_w);  m_sh = int'(crop_h);
        m_hd = int'(h_dec);   m_vd = int'(v_dec);
      end
      prev_vs = vs;
    end
  endtask

  task automatic line(input int row);
    for (int c = 0; c < L_PIX; c++) step(1'b0, 1'b0, 1'b1, c, row);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, row);
  endtask

  task automatic set_cfg(input int xs, input int ys, input int w, input int h,
                         input int hd, input int vd);
    x_start = 12'(xs); y_start = 12'(ys);
    crop_w  = 12'(w);  crop_h  = 12'(h);
    h_dec   = 2'(hd);  v_dec   = 2'(vd);
  endtask

  task automatic run_frame(input string name, input int exp_cnt,
                           input int chg_line = -1, input int chg_w = 0,
                           input int rst_line = -1);
    out_cnt = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < N_LINES; r++) begin
      if (r == chg_line) crop_w = 12'(chg_w);
      if (r == rst_line) begin
        step(1'b1, 1'b0, 1'b0, 0, r);
        step(1'b1, 1'b0, 1'b0, 0, r);
      end
      if (rst_line >= 0 && r == rst_line + 2) en = 1'b0;
      line(r);
    end
    check({"count_", name}, out_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; en_pin = 1'b1;
    pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
    set_cfg(0, 0, 1280, 720, 0, 0);
    fok = 1'b0; prev_vs = 1'b0;
    m_sx = 0; m_sy = 0; m_sw = 1280; m_sh = 720; m_hd = 0; m_vd = 0;

    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);

    // Default window is wider and taller than the frame: everything passes.
    run_frame("full", L_PIX * N_LINES);

    set_cfg(3, 2, 8, 4, 0, 0);
    run_frame("crop", 8 * 4);

    set_cfg(0, 0, 1280, 720, 1, 2);
    run_frame("decimate", 8 * 3);

    set_cfg(12, 0, 200, 720, 0, 0);
    run_frame("overhang", 4 * N_LINES);

    set_cfg(1, 1, 10, 5, 3, 1);
    run_frame("dec4_ceil", 3 * 3);

    set_cfg(0, 0, 0, 720, 0, 0);
    run_frame("zero_w", 0);

    set_cfg(0, 0, 1280, 0, 0, 0);
    run_frame("zero_h", 0);

    set_cfg(0, 0, 8, 720, 0, 0);
    run_frame("cfg_hold", 8 * N_LINES, 3, 4);
    run_frame("cfg_next", 4 * N_LINES);

    // Reset at line 4: lines 0-3 emitted, lines 4-5 suppressed, lines 6-7 mirrored with EN=0.
    set_cfg(0, 0, 1280, 720, 0, 0);
    en = 1'b1;
    run_frame("rst_mid", L_PIX * 4 + L_PIX * 2, -1, 0, 4);
    en = 1'b1;
    run_frame("after_rst", L_PIX * N_LINES);

    en = 1'b0;
    set_cfg(3, 2, 8, 4, 1, 1);
    run_frame("bypass", L_PIX * N_LINES);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
